// File: rtl/bus_write_ctrl.sv
// Paced nibble write controller: 2-deep request FIFO feeding a SETUP/PULSE/HOLD
// strobe sequencer that drives a quad tristate and an active-low RAM write strobe.
module bus_write_ctrl #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic [3:0] data_in,
    output logic       full,
    output logic [3:0] bus_data,
    output logic       bus_en,
    output logic       ram_we_n,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    // Counters hold "cycles remaining minus one" so a phase ends when they read zero.
    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    state_t     state;
    logic [3:0] cycCnt;
    logic [1:0] count;
    logic [3:0] fifoMem [2];
    logic       wrPtr;
    logic       rdPtr;
    logic       push;
    logic       pop;

    assign push = req && !full;
    assign pop  = (count != 2'd0) &&
                  ((state == IDLE) || (state == HOLD && cycCnt == 4'd0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= 2'd0;
            full    <= 1'b0;
            wrPtr   <= 1'b0;
            rdPtr   <= 1'b0;
            for (int i = 0; i < 2; i++) fifoMem[i] <= 4'd0;
        end else begin
            if (push) begin
                fifoMem[wrPtr] <= data_in;
                wrPtr          <= ~wrPtr;
            end
            if (pop) rdPtr <= ~rdPtr;
            case ({push, pop})
                2'b10: begin
                    count <= count + 2'd1;
                    full  <= (count == 2'd1);
                end
                2'b01: begin
                    count <= count - 2'd1;
                    full  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cycCnt   <= 4'd0;
            bus_data <= 4'd0;
            bus_en   <= 1'b0;
            ram_we_n <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= SETUP;
                        cycCnt   <= SETUP_LD;
                        bus_data <= fifoMem[rdPtr];
                        bus_en   <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cycCnt == 4'd0) begin
                        state    <= PULSE;
                        cycCnt   <= PULSE_LD;
                        ram_we_n <= 1'b0;
                    end else begin
                        cycCnt <= cycCnt - 4'd1;
                    end
                end
                PULSE: begin
                    if (cycCnt == 4'd0) begin
                        state    <= HOLD;
                        cycCnt   <= HOLD_LD;
                        ram_we_n <= 1'b1;
                        done     <= (HOLD_LD == 4'd0);
                    end else begin
                        cycCnt <= cycCnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cycCnt == 4'd0) begin
                        if (pop) begin
                            state    <= SETUP;
                            cycCnt   <= SETUP_LD;
                            bus_data <= fifoMem[rdPtr];
                        end else begin
                            state  <= IDLE;
                            cycCnt <= 4'd0;
                            bus_en <= 1'b0;
                        end
                    end else begin
                        cycCnt <= cycCnt - 4'd1;
                        done   <= (cycCnt == 4'd1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    cycCnt   <= 4'd0;
                    bus_en   <= 1'b0;
                    ram_we_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_write_ctrl.sv
// Scoreboard bench for bus_write_ctrl: expected nibbles queued at request time,
// popped on each done pulse; a per-cycle monitor checks strobe timing.
module tb_bus_write_ctrl;

    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic       full;
    logic [3:0] bus_data;
    logic       bus_en;
    logic       ram_we_n;
    logic       done;

    int         nChecks = 0;
    int         nFails = 0;
    int         cycleCnt = 0;
    int         acceptCount = 0;
    int         doneCount = 0;
    int         busEnCycles = 0;
    int         lastDone = 0;
    int         prevDone = 0;
    int         phase = 0;
    logic [3:0] capData = 4'd0;
    logic [3:0] sb [$];

    bus_write_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .data_in  (data_in),
        .full     (full),
        .bus_data (bus_data),
        .bus_en   (bus_en),
        .ram_we_n (ram_we_n),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendReq(input logic [3:0] d, input bit accept);
        req     = 1'b1;
        data_in = d;
        if (accept) begin
            sb.push_back(d);
            acceptCount++;
        end
        tick();
        req = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((sb.size() != 0 || bus_en) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) checkEq("idle_timeout", 32'd0, 32'd1);
    endtask

    // Per-cycle monitor: phase counts bus_en cycles within the current write.
    always @(negedge clk) begin
        if (!reset_n) begin
            phase = 0;
        end else if (bus_en === 1'b1) begin
            busEnCycles++;
            phase++;
            if (phase == 1) capData = bus_data;
            else checkEq("bus_data_stable", bus_data, capData);
            checkEq("ram_we_n_phase", ram_we_n, (phase > S && phase <= S + P) ? 1'b0 : 1'b1);
            checkEq("done_phase", done, (phase == S + P + H) ? 1'b1 : 1'b0);
            if (done === 1'b1) begin
                doneCount++;
                prevDone = lastDone;
                lastDone = cycleCnt;
                if (sb.size() == 0) checkEq("done_unexpected", 32'd1, 32'd0);
                else checkEq("bus_data_order", bus_data, sb.pop_front());
                phase = 0;
            end
        end else begin
            checkEq("window_complete", phase, 32'd0);
            if (ram_we_n === 1'b0) checkEq("we_without_en", bus_en, 1'b1);
            if (done === 1'b1) checkEq("done_while_idle", done, 1'b0);
            phase = 0;
        end
    end

    initial begin
        int t0;
        int n;
        int snap;

        repeat (2) tick();
        checkEq("rst_bus_en", bus_en, 1'b0);
        checkEq("rst_ram_we_n", ram_we_n, 1'b1);
        checkEq("rst_full", full, 1'b0);
        checkEq("rst_done", done, 1'b0);
        checkEq("rst_bus_data", bus_data, 4'h0);

        // Single write issued on the very first edge after reset release.
        reset_n = 1'b1;
        sendReq(4'b1100, 1'b1);
        t0 = cycleCnt;
        waitIdle();
        checkEq("single_latency", lastDone - t0, 32'd4);
        checkEq("single_idle_en", bus_en, 1'b0);

        // Back-to-back writes: done pulses exactly one window apart.
        sendReq(4'b0011, 1'b1);
        sendReq(4'b0101, 1'b1);
        waitIdle();
        checkEq("b2b_spacing", lastDone - prevDone, 32'd4);

        // Overflow: fourth request arrives while full and is dropped.
        sendReq(4'h1, 1'b1);
        sendReq(4'h2, 1'b1);
        sendReq(4'h3, 1'b1);
        checkEq("ovf_full_set", full, 1'b1);
        sendReq(4'h4, 1'b0);
        checkEq("ovf_full_hold", full, 1'b1);
        waitIdle();
        checkEq("ovf_full_clear", full, 1'b0);

        // Push coincides with the HOLD-exit pop while one entry is queued.
        sendReq(4'h7, 1'b1);
        sendReq(4'h8, 1'b1);
        repeat (3) tick();
        sendReq(4'hB, 1'b1);
        checkEq("coll_full", full, 1'b0);
        checkEq("coll_no_gap", bus_en, 1'b1);
        waitIdle();
        checkEq("coll_prev_spacing", lastDone - prevDone, 32'd4);

        // Reset while the strobe is low with one more entry queued.
        sendReq(4'h6, 1'b1);
        sendReq(4'h9, 1'b1);
        n = 0;
        while (ram_we_n !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) checkEq("pulse_timeout", 32'd0, 32'd1);
        reset_n = 1'b0;
        #1;
        checkEq("mid_rst_bus_en", bus_en, 1'b0);
        checkEq("mid_rst_ram_we_n", ram_we_n, 1'b1);
        checkEq("mid_rst_full", full, 1'b0);
        checkEq("mid_rst_done", done, 1'b0);
        checkEq("mid_rst_bus_data", bus_data, 4'h0);
        acceptCount -= sb.size();
        sb.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        snap = busEnCycles;
        repeat (10) tick();
        checkEq("no_write_after_rst", busEnCycles, snap);

        // Fresh request after the abort still writes normally.
        sendReq(4'hE, 1'b1);
        waitIdle();

        checkEq("done_vs_accepted", doneCount, acceptCount);
        checkEq("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
